// File: rtl/ysyx_22040125_mem_arbiter.sv
// ysyx_22040125_mem_arbiter
//   Shares the single memory bus port between instruction fetch (IF) and the load/store
//   unit (LSU). One requester owns the bus at a time. The granted transaction is latched
//   onto bus_* and held until bus_ack. Read data is returned to the owner with a one-cycle
//   rvalid pulse. LSU has priority, but after LSU_MAX consecutive LSU grants while IF waits,
//   IF is forced a grant. Fetch responses that arrive after a flush are dropped.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_req/if_addr/if_flush  fetch request, address, control-flow flush
//   if_rvalid/if_rdata       fetch response pulse and data
//   lsu_req/wen/addr/wdata/wmask  load/store request and payload
//   lsu_rvalid/lsu_rdata     access-complete pulse and load data
//   bus_req/wen/addr/wdata/wmask  registered bus transaction
//   bus_ack/bus_rdata        bus completion and read data
//   if_stall/lsu_stall       combinational stall requests to hazard control
module ysyx_22040125_mem_arbiter #(
  parameter int unsigned AW      = 64,
  parameter int unsigned DW      = 64,
  parameter int unsigned LSU_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  input  logic            if_flush,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            lsu_req,
  input  logic            lsu_wen,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic            lsu_rvalid,
  output logic [DW-1:0]   lsu_rdata,
  output logic            bus_req,
  output logic            bus_wen,
  output logic [AW-1:0]   bus_addr,
  output logic [DW-1:0]   bus_wdata,
  output logic [DW/8-1:0] bus_wmask,
  input  logic            bus_ack,
  input  logic [DW-1:0]   bus_rdata,
  output logic            if_stall,
  output logic            lsu_stall
);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyLsu} state_e;

  localparam logic [3:0] LsuMax = 4'(LSU_MAX);

  state_e            state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic              drop_q, drop_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_wen_q, bus_wen_d;
  logic [AW-1:0]     bus_addr_q, bus_addr_d;
  logic [DW-1:0]     bus_wdata_q, bus_wdata_d;
  logic [DW/8-1:0]   bus_wmask_q, bus_wmask_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic [DW-1:0]     if_rdata_q, if_rdata_d;
  logic              lsu_rvalid_q, lsu_rvalid_d;
  logic [DW-1:0]     lsu_rdata_q, lsu_rdata_d;
  logic              if_elig;

  // A flushed fetch is never worth starting.
  assign if_elig = if_req & ~if_flush;

  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    drop_d       = drop_q;
    bus_req_d    = bus_req_q;
    bus_wen_d    = bus_wen_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_wmask_d  = bus_wmask_q;
    if_rvalid_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    lsu_rvalid_d = 1'b0;
    lsu_rdata_d  = lsu_rdata_q;

    case (state_q)
      StIdle: begin
        drop_d = 1'b0;
        if (lsu_req && (!if_elig || (streak_q < LsuMax))) begin
          state_d     = StBusyLsu;
          bus_req_d   = 1'b1;
          bus_wen_d   = lsu_wen;
          bus_addr_d  = lsu_addr;
          bus_wdata_d = lsu_wdata;
          bus_wmask_d = lsu_wmask;
          // Streak only measures how long a waiting fetch has been passed over; the
          // guard above keeps it at or below LsuMax.
          streak_d    = if_elig ? streak_q + 4'd1 : 4'd0;
        end else if (if_elig) begin
          state_d     = StBusyIf;
          bus_req_d   = 1'b1;
          bus_wen_d   = 1'b0;
          bus_addr_d  = if_addr;
          bus_wdata_d = '0;
          bus_wmask_d = '0;
          streak_d    = 4'd0;
        end else begin
          streak_d = 4'd0;
        end
      end

      StBusyIf: begin
        if (bus_ack) begin
          state_d     = StIdle;
          drop_d      = 1'b0;
          bus_req_d   = 1'b0;
          bus_wen_d   = 1'b0;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
          bus_wmask_d = '0;
          // A flush in the ack cycle itself also kills the response.
          if (!(drop_q || if_flush)) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus_rdata;
          end
        end else if (if_flush) begin
          drop_d = 1'b1;
        end
      end

      StBusyLsu: begin
        if (bus_ack) begin
          state_d      = StIdle;
          bus_req_d    = 1'b0;
          bus_wen_d    = 1'b0;
          bus_addr_d   = '0;
          bus_wdata_d  = '0;
          bus_wmask_d  = '0;
          lsu_rvalid_d = 1'b1;
          lsu_rdata_d  = bus_rdata;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      streak_q     <= 4'd0;
      drop_q       <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_wen_q    <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_wmask_q  <= '0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      lsu_rvalid_q <= 1'b0;
      lsu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      drop_q       <= drop_d;
      bus_req_q    <= bus_req_d;
      bus_wen_q    <= bus_wen_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_wmask_q  <= bus_wmask_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      lsu_rvalid_q <= lsu_rvalid_d;
      lsu_rdata_q  <= lsu_rdata_d;
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_wen    = bus_wen_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_wmask  = bus_wmask_q;
  assign if_rvalid  = if_rvalid_q;
  assign if_rdata   = if_rdata_q;
  assign lsu_rvalid = lsu_rvalid_q;
  assign lsu_rdata  = lsu_rdata_q;

  assign if_stall   = if_req & ~if_rvalid_q;
  assign lsu_stall  = lsu_req & ~lsu_rvalid_q;

endmodule
